// File: rtl/keypad_timer_entry.sv
// Purpose: debounced one-hot keypad entry into a BCD shift register, plus a free-running pgt_1Hz divider.
// Latency: a key stable before edge 1 strobes loadn low from edge DEBOUNCE to edge DEBOUNCE+1.
// Backpressure: none; keys are dropped while enablen=1, while held, or when full with OVERWRITE=0.
//
// Ports:
//   clk100   - system clock, all state on its rising edge
//   clearn   - asynchronous active-low reset
//   keypad   - one-hot key lines, bit i = digit i
//   enablen  - active-low entry enable
//   D        - BCD code of the last accepted key
//   loadn    - active-low one-cycle strobe per accepted key
//   pgt_1Hz  - square wave, period DIV cycles, 50% duty
//   digits   - entry register, digits[3:0] = most recent key
//   count    - number of digits entered, saturating at DIGITS
//   full     - count == DIGITS
module keypad_timer_entry #(
    parameter int DIGITS    = 4,
    parameter int DIV       = 100,
    parameter int DEBOUNCE  = 2,
    parameter int OVERWRITE = 1
) (
    input  logic                  clk100,
    input  logic                  clearn,
    input  logic [9:0]            keypad,
    input  logic                  enablen,
    output logic [3:0]            D,
    output logic                  loadn,
    output logic                  pgt_1Hz,
    output logic [4*DIGITS-1:0]   digits,
    output logic [3:0]            count,
    output logic                  full
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int DW = $clog2(DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STABLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   stab_cnt, stab_nxt;
    logic [CW-1:0]   rel_cnt, rel_nxt;
    logic [3:0]      cur_code, code_nxt;
    logic            fire;

    logic [3:0]      kp_code;
    logic [3:0]      kp_ones;
    logic            kp_valid;
    logic            kp_released;

    logic            accept;
    logic [3:0]      count_nxt;
    logic [4*DIGITS-1:0] digits_shift;

    logic [DW-1:0]   div_cnt, div_nxt;

    // Keypad decode. A multi-key sample is neither valid nor released: it
    // cannot start a press, and it cannot count toward releasing one.
    always_comb begin
        kp_code = '0;
        kp_ones = '0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) begin
                kp_code = 4'(i);
                kp_ones = kp_ones + 4'd1;
            end
        end
    end

    assign kp_valid    = (kp_ones == 4'd1);
    assign kp_released = (kp_ones == 4'd0);

    // State register
    always_ff @(posedge clk100 or negedge clearn) begin
        if (!clearn) begin
            state    <= IDLE;
            stab_cnt <= '0;
            rel_cnt  <= '0;
            cur_code <= '0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_nxt;
            rel_cnt  <= rel_nxt;
            cur_code <= code_nxt;
        end
    end

    // Next-state logic. fire marks the edge on which the debounce count is
    // reached; enablen is applied afterwards so a disabled press is still
    // consumed and must be released before another key is seen.
    always_comb begin
        state_nxt = state;
        stab_nxt  = stab_cnt;
        rel_nxt   = rel_cnt;
        code_nxt  = cur_code;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if (kp_valid) begin
                    code_nxt = kp_code;
                    stab_nxt = CW'(1);
                    rel_nxt  = '0;
                    if (DEBOUNCE == 1) begin
                        fire      = 1'b1;
                        state_nxt = HELD;
                    end else begin
                        state_nxt = STABLE;
                    end
                end
            end
            STABLE: begin
                if (!kp_valid) begin
                    state_nxt = IDLE;
                    stab_nxt  = '0;
                end else if (kp_code != cur_code) begin
                    code_nxt = kp_code;
                    stab_nxt = CW'(1);
                end else begin
                    stab_nxt = stab_cnt + CW'(1);
                    if (stab_nxt == CW'(DEBOUNCE)) begin
                        fire      = 1'b1;
                        state_nxt = HELD;
                        rel_nxt   = '0;
                    end
                end
            end
            HELD: begin
                if (kp_released) begin
                    rel_nxt = rel_cnt + CW'(1);
                    if (rel_nxt == CW'(DEBOUNCE)) begin
                        state_nxt = IDLE;
                        rel_nxt   = '0;
                        stab_nxt  = '0;
                    end
                end else begin
                    rel_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                stab_nxt  = '0;
                rel_nxt   = '0;
            end
        endcase
    end

    // Output decisions derived from the FSM
    always_comb begin
        accept    = fire && !enablen && (!full || (OVERWRITE != 0));
        count_nxt = (count < 4'(DIGITS)) ? count + 4'd1 : count;
    end

    generate
        if (DIGITS == 1) begin : g_one
            assign digits_shift = code_nxt;
        end else begin : g_many
            assign digits_shift = {digits[4*DIGITS-5:0], code_nxt};
        end
    endgenerate

    always_ff @(posedge clk100 or negedge clearn) begin
        if (!clearn) begin
            D      <= '0;
            loadn  <= 1'b1;
            digits <= '0;
            count  <= '0;
        end else begin
            loadn <= !accept;
            if (accept) begin
                D      <= code_nxt;
                digits <= digits_shift;
                count  <= count_nxt;
            end
        end
    end

    assign full = (count == 4'(DIGITS));

    // Free-running divider; pgt_1Hz is registered from the next counter
    // value so it is low for counts 0..DIV/2-1 and high for DIV/2..DIV-1.
    assign div_nxt = (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + DW'(1);

    always_ff @(posedge clk100 or negedge clearn) begin
        if (!clearn) begin
            div_cnt <= '0;
            pgt_1Hz <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            pgt_1Hz <= (div_nxt >= DW'(DIV / 2));
        end
    end

endmodule

// File: tb/tb_keypad_timer_entry.sv
module tb_keypad_timer_entry;

    logic        clk100 = 1'b0;
    logic        clearn;
    logic [9:0]  keypad;
    logic        enablen;

    logic [3:0]  d0, d1, cnt0, cnt1;
    logic        ld0, ld1, pgt0, pgt1, full0, full1;
    logic [15:0] dig0, dig1;

    int checks = 0;
    int errors = 0;
    int s0, s1;

    always #5 clk100 = ~clk100;

    keypad_timer_entry #(.DIGITS(4), .DIV(100), .DEBOUNCE(2), .OVERWRITE(1)) dut_ow (
        .clk100(clk100), .clearn(clearn), .keypad(keypad), .enablen(enablen),
        .D(d0), .loadn(ld0), .pgt_1Hz(pgt0), .digits(dig0), .count(cnt0), .full(full0)
    );

    keypad_timer_entry #(.DIGITS(4), .DIV(100), .DEBOUNCE(2), .OVERWRITE(0)) dut_keep (
        .clk100(clk100), .clearn(clearn), .keypad(keypad), .enablen(enablen),
        .D(d1), .loadn(ld1), .pgt_1Hz(pgt1), .digits(dig1), .count(cnt1), .full(full1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and tally loadn strobes from the
    // preceding rising edge.
    task automatic step();
        @(negedge clk100);
        if (ld0 === 1'b0) s0++;
        if (ld1 === 1'b0) s1++;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_d0"}, {28'd0, d0}, 0);
        chk({tag, "_ld0"}, {31'd0, ld0}, 1);
        chk({tag, "_pgt0"}, {31'd0, pgt0}, 0);
        chk({tag, "_dig0"}, {16'd0, dig0}, 0);
        chk({tag, "_cnt0"}, {28'd0, cnt0}, 0);
        chk({tag, "_full0"}, {31'd0, full0}, 0);
        chk({tag, "_dig1"}, {16'd0, dig1}, 0);
        chk({tag, "_ld1"}, {31'd0, ld1}, 1);
    endtask

    typedef struct {
        logic [9:0]  kp;
        logic        en;
        int          hold;
        logic [3:0]  d0;
        logic [15:0] g0;
        logic [3:0]  c0;
        logic        f0;
        int          st0;
        logic [3:0]  d1;
        logic [15:0] g1;
        logic [3:0]  c1;
        logic        f1;
        int          st1;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int pgt_bad;
        int first_bad;
        int rises;
        logic prev_pgt;
        logic exp_pgt;
        int waited;

        // kp, enablen, hold, {D, digits, count, full, strobes} x (overwrite, keep)
        vecs[0] = '{10'b0000000010, 1'b0, 6, 4'd1, 16'h0091, 4'd2, 1'b0, 1, 4'd1, 16'h0091, 4'd2, 1'b0, 1};
        vecs[1] = '{10'b0000000100, 1'b0, 6, 4'd2, 16'h0912, 4'd3, 1'b0, 1, 4'd2, 16'h0912, 4'd3, 1'b0, 1};
        vecs[2] = '{10'b0000001000, 1'b0, 6, 4'd3, 16'h9123, 4'd4, 1'b1, 1, 4'd3, 16'h9123, 4'd4, 1'b1, 1};
        vecs[3] = '{10'b0000010000, 1'b0, 6, 4'd4, 16'h1234, 4'd4, 1'b1, 1, 4'd3, 16'h9123, 4'd4, 1'b1, 0};
        vecs[4] = '{10'b0000100000, 1'b0, 6, 4'd5, 16'h2345, 4'd4, 1'b1, 1, 4'd3, 16'h9123, 4'd4, 1'b1, 0};
        vecs[5] = '{10'b0100000000, 1'b1, 6, 4'd5, 16'h2345, 4'd4, 1'b1, 0, 4'd3, 16'h9123, 4'd4, 1'b1, 0};
        vecs[6] = '{10'b0000001100, 1'b0, 6, 4'd5, 16'h2345, 4'd4, 1'b1, 0, 4'd3, 16'h9123, 4'd4, 1'b1, 0};
        vecs[7] = '{10'b0010000000, 1'b0, 6, 4'd7, 16'h3457, 4'd4, 1'b1, 1, 4'd3, 16'h9123, 4'd4, 1'b1, 0};
        vecs[8] = '{10'b0000000001, 1'b0, 6, 4'd0, 16'h4570, 4'd4, 1'b1, 1, 4'd3, 16'h9123, 4'd4, 1'b1, 0};

        clearn  = 1'b0;
        keypad  = '0;
        enablen = 1'b1;
        s0 = 0;
        s1 = 0;
        repeat (3) step();
        check_reset_vals("reset");

        // Key 9 held 200 cycles: one strobe, at edge 2 only.
        clearn  = 1'b1;
        keypad  = 10'b1000000000;
        enablen = 1'b0;
        s0 = 0;
        s1 = 0;
        step();
        chk("hold9_edge1_loadn", {31'd0, ld0}, 1);
        step();
        chk("hold9_edge2_loadn", {31'd0, ld0}, 0);
        chk("hold9_edge2_D", {28'd0, d0}, 9);
        step();
        chk("hold9_edge3_loadn", {31'd0, ld0}, 1);
        repeat (197) step();
        keypad = '0;
        repeat (4) step();
        chk("hold9_strobes", s0, 1);
        chk("hold9_digits", {16'd0, dig0}, 32'h0009);
        chk("hold9_count", {28'd0, cnt0}, 1);
        chk("hold9_keep_digits", {16'd0, dig1}, 32'h0009);

        for (int v = 0; v < 9; v++) begin
            s0 = 0;
            s1 = 0;
            keypad  = vecs[v].kp;
            enablen = vecs[v].en;
            repeat (vecs[v].hold) step();
            keypad  = '0;
            enablen = 1'b0;
            repeat (4) step();
            chk($sformatf("vec%0d_D_ow", v), {28'd0, d0}, {28'd0, vecs[v].d0});
            chk($sformatf("vec%0d_digits_ow", v), {16'd0, dig0}, {16'd0, vecs[v].g0});
            chk($sformatf("vec%0d_count_ow", v), {28'd0, cnt0}, {28'd0, vecs[v].c0});
            chk($sformatf("vec%0d_full_ow", v), {31'd0, full0}, {31'd0, vecs[v].f0});
            chk($sformatf("vec%0d_strobes_ow", v), s0, vecs[v].st0);
            chk($sformatf("vec%0d_D_keep", v), {28'd0, d1}, {28'd0, vecs[v].d1});
            chk($sformatf("vec%0d_digits_keep", v), {16'd0, dig1}, {16'd0, vecs[v].g1});
            chk($sformatf("vec%0d_count_keep", v), {28'd0, cnt1}, {28'd0, vecs[v].c1});
            chk($sformatf("vec%0d_full_keep", v), {31'd0, full1}, {31'd0, vecs[v].f1});
            chk($sformatf("vec%0d_strobes_keep", v), s1, vecs[v].st1);
        end

        // Key pressed while disabled, then enabled while still held: no strobe
        // until the key is released and pressed again.
        s0 = 0;
        s1 = 0;
        keypad  = 10'b0100000000;
        enablen = 1'b1;
        repeat (10) step();
        enablen = 1'b0;
        repeat (10) step();
        chk("en_late_strobes", s0, 0);
        chk("en_late_digits", {16'd0, dig0}, 32'h4570);
        keypad = '0;
        repeat (4) step();
        keypad = 10'b0100000000;
        repeat (6) step();
        keypad = '0;
        repeat (4) step();
        chk("repress_strobes", s0, 1);
        chk("repress_D", {28'd0, d0}, 8);
        chk("repress_digits", {16'd0, dig0}, 32'h5708);
        chk("repress_keep_strobes", s1, 0);

        // One-cycle glitch, then a two-key chord: nothing accepted.
        s0 = 0;
        s1 = 0;
        keypad = 10'b0000001000;
        step();
        keypad = 10'b0000001100;
        repeat (10) step();
        keypad = '0;
        repeat (4) step();
        chk("glitch_strobes_ow", s0, 0);
        chk("glitch_strobes_keep", s1, 0);
        chk("glitch_digits", {16'd0, dig0}, 32'h5708);

        // Wait for pgt_1Hz high so the reset visibly pulls it low.
        waited = 0;
        while (pgt0 !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        chk("pgt_seen_high", {31'd0, pgt0}, 1);

        // Reset in the middle of a press of key 5.
        keypad = 10'b0000100000;
        step();
        clearn = 1'b0;
        #1;
        check_reset_vals("midreset");
        repeat (3) step();

        // Release reset with key 5 still held: a fresh press from IDLE, and
        // the divider restarts from zero.
        @(negedge clk100);
        clearn = 1'b1;
        s0 = 0;
        s1 = 0;
        pgt_bad = 0;
        first_bad = -1;
        rises = 0;
        prev_pgt = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            step();
            exp_pgt = ((k % 100) >= 50);
            if (pgt0 !== exp_pgt) begin
                pgt_bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (pgt0 === 1'b1 && prev_pgt === 1'b0) rises++;
            prev_pgt = pgt0;
            if (k == 1) chk("postreset_edge1_loadn", {31'd0, ld0}, 1);
            if (k == 2) begin
                chk("postreset_edge2_loadn", {31'd0, ld0}, 0);
                chk("postreset_D", {28'd0, d0}, 5);
                chk("postreset_digits_ow", {16'd0, dig0}, 32'h0005);
                chk("postreset_digits_keep", {16'd0, dig1}, 32'h0005);
                chk("postreset_count", {28'd0, cnt0}, 1);
            end
            if (k == 10) keypad = '0;
        end
        chk("postreset_strobes", s0, 1);
        chk("pgt_pattern_bad_samples", pgt_bad, 0);
        if (pgt_bad != 0) $display("first pgt sample off at cycle %0d", first_bad);
        chk("pgt_rises_in_400", rises, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
